// File: rtl/pulse_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_scheduler
//
// Burst sequencer for the synthesizer output stage. On an accepted START it
// latches a burst configuration (signal type, pulse length, pulse period,
// pulse count). It then issues one-cycle start/stop strobes to the selected
// waveform generator and to output_reg. Every pulse start is gated on
// output_reg's READY so that pulses never overlap in the output stage.
//
// Ports
//   CLK                    system clock
//   RESET                  synchronous, active-high reset
//   START                  burst request, only looked at while idle
//   ABORT                  terminate the current burst
//   SIGNAL_TYPE [1:0]      1=LFM, 2=PSK, 3=noise, 0=invalid
//   PULSE_LEN   [LEN_W]    clocks from start strobe to stop strobe
//   PULSE_PERIOD[PER_W]    clocks between consecutive start strobes
//   PULSE_NUM   [NUM_W]    pulses per burst
//   READY_IN               READY from output_reg
//   SIGN_*_START_CALC      one-cycle start strobe per generator
//   SIGN_*_STOP_CALC       one-cycle stop strobe per generator
//   BUSY                   high whenever the sequencer is not idle
//   DONE                   one-cycle burst-complete pulse
//   CFG_ERR                one-cycle pulse when a START is rejected
//   OVERRUN                sticky: a period boundary found READY_IN low
//   PULSE_CNT   [NUM_W]    start strobes issued in the current burst
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pulse_scheduler #(
  parameter int LEN_W = 16,
  parameter int PER_W = 20,
  parameter int NUM_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       SIGNAL_TYPE,
  input  logic [LEN_W-1:0] PULSE_LEN,
  input  logic [PER_W-1:0] PULSE_PERIOD,
  input  logic [NUM_W-1:0] PULSE_NUM,
  input  logic             READY_IN,
  output logic             SIGN_LFM_START_CALC,
  output logic             SIGN_PSK_START_CALC,
  output logic             SIGN_NOISE_START_CALC,
  output logic             SIGN_LFM_STOP_CALC,
  output logic             SIGN_PSK_STOP_CALC,
  output logic             SIGN_NOISE_STOP_CALC,
  output logic             BUSY,
  output logic             DONE,
  output logic             CFG_ERR,
  output logic             OVERRUN,
  output logic [NUM_W-1:0] PULSE_CNT
);

  // Common width for comparing pulse length against timer/period values.
  localparam int CMP_W = (LEN_W > PER_W) ? LEN_W : PER_W;

  typedef enum logic [1:0] {
    SIG_NONE  = 2'd0,
    SIG_LFM   = 2'd1,
    SIG_PSK   = 2'd2,
    SIG_NOISE = 2'd3
  } sig_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ACTIVE,
    S_GAP,
    S_DRAIN
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  sig_t             r_type;
  logic [LEN_W-1:0] r_len;
  logic [PER_W-1:0] r_period;
  logic [NUM_W-1:0] r_num;
  logic [PER_W-1:0] r_timer;
  logic [NUM_W-1:0] r_cnt;
  logic             r_lfm_start;
  logic             r_psk_start;
  logic             r_noise_start;
  logic             r_lfm_stop;
  logic             r_psk_stop;
  logic             r_noise_stop;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;
  logic             r_overrun;

  // ---------------------------------------------------------------------------
  // Next-state / next-value wires
  // ---------------------------------------------------------------------------
  state_t           w_state_nx;
  sig_t             w_type_nx;
  logic [LEN_W-1:0] w_len_nx;
  logic [PER_W-1:0] w_period_nx;
  logic [NUM_W-1:0] w_num_nx;
  logic [PER_W-1:0] w_timer_nx;
  logic [NUM_W-1:0] w_cnt_nx;
  logic             w_fire_start;
  logic             w_fire_stop;
  logic             w_done_nx;
  logic             w_cfg_err_nx;
  logic             w_overrun_nx;

  logic             w_cfg_ok;
  logic [PER_W-1:0] w_timer_inc;
  logic             w_hit_len;
  logic             w_hit_per;

  assign w_cfg_ok = (SIGNAL_TYPE != 2'd0)
                 && (PULSE_LEN != '0)
                 && (PULSE_NUM != '0)
                 && (CMP_W'(PULSE_PERIOD) > CMP_W'(PULSE_LEN));

  // The timer holds t for the current cycle; decisions are made on the value
  // t will take after the edge so the registered strobe lands exactly on it.
  assign w_timer_inc = r_timer + PER_W'(1);
  assign w_hit_len   = (CMP_W'(w_timer_inc) == CMP_W'(r_len));
  assign w_hit_per   = (w_timer_inc == r_period);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    w_state_nx   = r_state;
    w_type_nx    = r_type;
    w_len_nx     = r_len;
    w_period_nx  = r_period;
    w_num_nx     = r_num;
    w_timer_nx   = r_timer;
    w_cnt_nx     = r_cnt;
    w_fire_start = 1'b0;
    w_fire_stop  = 1'b0;
    w_done_nx    = 1'b0;
    w_cfg_err_nx = 1'b0;
    w_overrun_nx = r_overrun;

    unique case (r_state)
      S_IDLE: begin
        // START together with ABORT is deliberately a no-op.
        if (START && !ABORT) begin
          if (w_cfg_ok) begin
            w_type_nx    = sig_t'(SIGNAL_TYPE);
            w_len_nx     = PULSE_LEN;
            w_period_nx  = PULSE_PERIOD;
            w_num_nx     = PULSE_NUM;
            w_cnt_nx     = '0;
            w_overrun_nx = 1'b0;
            w_timer_nx   = '0;
            w_state_nx   = S_WAIT_RDY;
          end else begin
            w_cfg_err_nx = 1'b1;
          end
        end
      end

      S_WAIT_RDY: begin
        if (ABORT) begin
          w_state_nx = S_DRAIN;
        end else if (READY_IN) begin
          w_fire_start = 1'b1;
          w_cnt_nx     = r_cnt + NUM_W'(1);
          w_timer_nx   = '0;
          w_state_nx   = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        w_timer_nx = w_timer_inc;
        // An abort turns into a stop strobe on the next cycle; if the natural
        // stop falls on the same edge it is the same single strobe.
        if (ABORT || w_hit_len) begin
          w_fire_stop = 1'b1;
          w_state_nx  = ABORT ? S_DRAIN : S_GAP;
        end
      end

      S_GAP: begin
        w_timer_nx = w_timer_inc;
        if (ABORT || (r_cnt == r_num)) begin
          w_state_nx = S_DRAIN;
        end else if (w_hit_per) begin
          if (READY_IN) begin
            w_fire_start = 1'b1;
            w_cnt_nx     = r_cnt + NUM_W'(1);
            w_timer_nx   = '0;
            w_state_nx   = S_ACTIVE;
          end else begin
            // Output stage still busy at the period boundary: flag it and
            // start late; the timer restarts from that late start.
            w_overrun_nx = 1'b1;
            w_state_nx   = S_WAIT_RDY;
          end
        end
      end

      S_DRAIN: begin
        if (READY_IN) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_type        <= SIG_NONE;
      r_len         <= '0;
      r_period      <= '0;
      r_num         <= '0;
      r_timer       <= '0;
      r_cnt         <= '0;
      r_lfm_start   <= 1'b0;
      r_psk_start   <= 1'b0;
      r_noise_start <= 1'b0;
      r_lfm_stop    <= 1'b0;
      r_psk_stop    <= 1'b0;
      r_noise_stop  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_type        <= w_type_nx;
      r_len         <= w_len_nx;
      r_period      <= w_period_nx;
      r_num         <= w_num_nx;
      r_timer       <= w_timer_nx;
      r_cnt         <= w_cnt_nx;
      // Strobes are only ever fired outside IDLE, so r_type already holds
      // the latched type whenever one of them is decoded here.
      r_lfm_start   <= w_fire_start && (r_type == SIG_LFM);
      r_psk_start   <= w_fire_start && (r_type == SIG_PSK);
      r_noise_start <= w_fire_start && (r_type == SIG_NOISE);
      r_lfm_stop    <= w_fire_stop  && (r_type == SIG_LFM);
      r_psk_stop    <= w_fire_stop  && (r_type == SIG_PSK);
      r_noise_stop  <= w_fire_stop  && (r_type == SIG_NOISE);
      r_busy        <= (w_state_nx != S_IDLE);
      r_done        <= w_done_nx;
      r_cfg_err     <= w_cfg_err_nx;
      r_overrun     <= w_overrun_nx;
    end
  end

  assign SIGN_LFM_START_CALC   = r_lfm_start;
  assign SIGN_PSK_START_CALC   = r_psk_start;
  assign SIGN_NOISE_START_CALC = r_noise_start;
  assign SIGN_LFM_STOP_CALC    = r_lfm_stop;
  assign SIGN_PSK_STOP_CALC    = r_psk_stop;
  assign SIGN_NOISE_STOP_CALC  = r_noise_stop;
  assign BUSY                  = r_busy;
  assign DONE                  = r_done;
  assign CFG_ERR               = r_cfg_err;
  assign OVERRUN               = r_overrun;
  assign PULSE_CNT             = r_cnt;

endmodule

// File: tb/tb_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pulse_scheduler
//
// Table-driven bench for pulse_scheduler. Each vector describes one burst
// request (config, abort cycle, READY_IN low window) and the hand-computed
// cycle numbers of the resulting strobes. Cycle n is the state seen just after
// the n-th clock edge of the vector; START is high in cycle 0. Hand-written
// sequences cover the reset state and a reset in the middle of a pulse.
// -----------------------------------------------------------------------------
module tb_pulse_scheduler;

  localparam int LEN_W = 16;
  localparam int PER_W = 20;
  localparam int NUM_W = 8;

  logic             CLK;
  logic             RESET;
  logic             START;
  logic             ABORT;
  logic [1:0]       SIGNAL_TYPE;
  logic [LEN_W-1:0] PULSE_LEN;
  logic [PER_W-1:0] PULSE_PERIOD;
  logic [NUM_W-1:0] PULSE_NUM;
  logic             READY_IN;
  logic             SIGN_LFM_START_CALC;
  logic             SIGN_PSK_START_CALC;
  logic             SIGN_NOISE_START_CALC;
  logic             SIGN_LFM_STOP_CALC;
  logic             SIGN_PSK_STOP_CALC;
  logic             SIGN_NOISE_STOP_CALC;
  logic             BUSY;
  logic             DONE;
  logic             CFG_ERR;
  logic             OVERRUN;
  logic [NUM_W-1:0] PULSE_CNT;

  pulse_scheduler #(
    .LEN_W(LEN_W),
    .PER_W(PER_W),
    .NUM_W(NUM_W)
  ) dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .START                (START),
    .ABORT                (ABORT),
    .SIGNAL_TYPE          (SIGNAL_TYPE),
    .PULSE_LEN            (PULSE_LEN),
    .PULSE_PERIOD         (PULSE_PERIOD),
    .PULSE_NUM            (PULSE_NUM),
    .READY_IN             (READY_IN),
    .SIGN_LFM_START_CALC  (SIGN_LFM_START_CALC),
    .SIGN_PSK_START_CALC  (SIGN_PSK_START_CALC),
    .SIGN_NOISE_START_CALC(SIGN_NOISE_START_CALC),
    .SIGN_LFM_STOP_CALC   (SIGN_LFM_STOP_CALC),
    .SIGN_PSK_STOP_CALC   (SIGN_PSK_STOP_CALC),
    .SIGN_NOISE_STOP_CALC (SIGN_NOISE_STOP_CALC),
    .BUSY                 (BUSY),
    .DONE                 (DONE),
    .CFG_ERR              (CFG_ERR),
    .OVERRUN              (OVERRUN),
    .PULSE_CNT            (PULSE_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One burst request and its expected outcome (-1 = never happens).
  typedef struct {
    int typ;
    int len;
    int per;
    int num;
    int abort_cyc;  // cycle in which ABORT is held high
    int rlo;        // first cycle with READY_IN low
    int rhi;        // last cycle with READY_IN low
    int e_cfg;      // cycle CFG_ERR is high
    int e_nst;      // number of start strobes
    int e_nsp;      // number of stop strobes
    int e_lst;      // cycle of the last start strobe
    int e_lsp;      // cycle of the last stop strobe
    int e_done;     // cycle DONE is high
    int e_cnt;      // PULSE_CNT at the end
    int e_ovr;      // OVERRUN at the end
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  function automatic logic [2:0] type_mask(input int typ);
    case (typ)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic run_vec(input int idx);
    vec_t       v;
    int         nst, nsp, lst, lsp, dn, cf, bad, busy1, budget;
    logic [2:0] w_st, w_sp, mask;
    string      tag;
    v      = vecs[idx];
    tag    = $sformatf("v%0d", idx);
    nst    = 0;
    nsp    = 0;
    lst    = -1;
    lsp    = -1;
    dn     = -1;
    cf     = -1;
    bad    = 0;
    busy1  = 0;
    mask   = type_mask(v.typ);
    budget = (v.e_done >= 0) ? v.e_done + 10 : 20;
    for (int e = 1; e <= budget; e++) begin
      START    = (e == 1);
      ABORT    = ((e - 1) == v.abort_cyc);
      READY_IN = !(((e - 1) >= v.rlo) && ((e - 1) <= v.rhi));
      if (e == 1) begin
        SIGNAL_TYPE  = 2'(v.typ);
        PULSE_LEN    = LEN_W'(v.len);
        PULSE_PERIOD = PER_W'(v.per);
        PULSE_NUM    = NUM_W'(v.num);
      end else begin
        // Scramble config after the request: it must already be latched.
        SIGNAL_TYPE  = ~2'(v.typ);
        PULSE_LEN    = '1;
        PULSE_PERIOD = PER_W'(3);
        PULSE_NUM    = '1;
      end
      @(posedge CLK);
      #1;
      w_st = {SIGN_LFM_START_CALC, SIGN_PSK_START_CALC, SIGN_NOISE_START_CALC};
      w_sp = {SIGN_LFM_STOP_CALC, SIGN_PSK_STOP_CALC, SIGN_NOISE_STOP_CALC};
      if ($countones({w_st, w_sp}) > 1) bad++;
      if (((w_st | w_sp) & ~mask) != 3'b000) bad++;
      if (w_st != 3'b000) begin nst++; lst = e; end
      if (w_sp != 3'b000) begin nsp++; lsp = e; end
      if (DONE) begin
        if (dn >= 0) bad++;
        dn = e;
      end
      if (CFG_ERR) begin
        if (cf >= 0) bad++;
        cf = e;
      end
      if (e == 1) busy1 = int'(BUSY);
    end
    START = 1'b0;
    ABORT = 1'b0;
    check({tag, " cfg_err_cycle"}, cf, v.e_cfg);
    check({tag, " start_count"},   nst, v.e_nst);
    check({tag, " stop_count"},    nsp, v.e_nsp);
    check({tag, " last_start"},    lst, v.e_lst);
    check({tag, " last_stop"},     lsp, v.e_lsp);
    check({tag, " done_cycle"},    dn, v.e_done);
    check({tag, " pulse_cnt"},     int'(PULSE_CNT), v.e_cnt);
    check({tag, " overrun"},       int'(OVERRUN), v.e_ovr);
    check({tag, " bad_strobes"},   bad, 0);
    check({tag, " busy_cycle1"},   busy1, (v.e_done >= 0) ? 1 : 0);
    check({tag, " busy_end"},      int'(BUSY), 0);
  endtask

  initial begin
    int         nstr;
    logic [14:0] w_all;

    //           typ len  per num abt  rlo rhi cfg nst nsp lst lsp done cnt ovr
    vecs[0]  = '{1, 10,  50, 1, -1,  -1, -1, -1, 1, 1,  2, 12, 14, 1, 0}; // single LFM
    vecs[1]  = '{2,  5,  40, 3, -1,  -1, -1, -1, 3, 3, 82, 87, 89, 3, 0}; // PSK burst
    vecs[2]  = '{3,  5,  20, 2, -1,   3, 29, -1, 2, 2, 31, 36, 38, 2, 1}; // overrun
    vecs[3]  = '{0,  5,  20, 2, -1,  -1, -1,  1, 0, 0, -1, -1, -1, 2, 1}; // type 0
    vecs[4]  = '{1,  8,   8, 1, -1,  -1, -1,  1, 0, 0, -1, -1, -1, 2, 1}; // per == len
    vecs[5]  = '{2,  5,  20, 0, -1,  -1, -1,  1, 0, 0, -1, -1, -1, 2, 1}; // num 0
    vecs[6]  = '{1,  0,  10, 1, -1,  -1, -1,  1, 0, 0, -1, -1, -1, 2, 1}; // len 0
    vecs[7]  = '{1, 100, 200, 2, 22, -1, -1, -1, 1, 1,  2, 23, 24, 1, 0}; // abort ACTIVE
    vecs[8]  = '{2,  5,  40, 3, 20,  -1, -1, -1, 1, 1,  2,  7, 22, 1, 0}; // abort GAP
    vecs[9]  = '{1,  1,   2, 3, -1,  -1, -1, -1, 3, 3,  6,  7,  9, 3, 0}; // min len/per
    vecs[10] = '{3,  5,  20, 1,  5,   1, 10, -1, 0, 0, -1, -1, 12, 0, 0}; // abort WAIT_RDY
    vecs[11] = '{1, 10,  50, 1,  0,  -1, -1, -1, 0, 0, -1, -1, -1, 0, 0}; // START+ABORT

    RESET        = 1'b1;
    START        = 1'b0;
    ABORT        = 1'b0;
    SIGNAL_TYPE  = 2'd0;
    PULSE_LEN    = '0;
    PULSE_PERIOD = '0;
    PULSE_NUM    = '0;
    READY_IN     = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    w_all = {SIGN_LFM_START_CALC, SIGN_PSK_START_CALC, SIGN_NOISE_START_CALC,
             SIGN_LFM_STOP_CALC, SIGN_PSK_STOP_CALC, SIGN_NOISE_STOP_CALC,
             BUSY, DONE, CFG_ERR, OVERRUN, 5'(PULSE_CNT)};
    check("reset_outputs", int'(w_all), 0);
    check("reset_cnt", int'(PULSE_CNT), 0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Reset at t=3 of a pulse: everything drops on the next cycle, no stop.
    SIGNAL_TYPE  = 2'd1;
    PULSE_LEN    = LEN_W'(10);
    PULSE_PERIOD = PER_W'(50);
    PULSE_NUM    = NUM_W'(1);
    READY_IN     = 1'b1;
    START        = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);  // now in cycle 5, t = 3
    #1;
    check("midreset_busy_before", int'(BUSY), 1);
    check("midreset_cnt_before", int'(PULSE_CNT), 1);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    w_all = {SIGN_LFM_START_CALC, SIGN_PSK_START_CALC, SIGN_NOISE_START_CALC,
             SIGN_LFM_STOP_CALC, SIGN_PSK_STOP_CALC, SIGN_NOISE_STOP_CALC,
             BUSY, DONE, CFG_ERR, OVERRUN, 5'(PULSE_CNT)};
    check("midreset_outputs", int'(w_all), 0);
    nstr = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge CLK);
      #1;
      nstr += $countones({SIGN_LFM_START_CALC, SIGN_PSK_START_CALC,
                          SIGN_NOISE_START_CALC, SIGN_LFM_STOP_CALC,
                          SIGN_PSK_STOP_CALC, SIGN_NOISE_STOP_CALC,
                          BUSY, DONE});
    end
    check("midreset_quiet", nstr, 0);

    // A fresh burst after the reset behaves normally.
    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
